// File: rtl/axil_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axil_req_arbiter
//  Description : Round-robin arbiter that shares a single AXI4-Lite master
//                port between NUM_REQ local valid/ready requesters. Only one
//                transaction is in flight at a time; each requester receives
//                a one-cycle response pulse with read data and response code.
//                Optional build macro ARB_FIXED_PRIO0_EN gives requester 0
//                absolute priority while the others rotate among themselves.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_req_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    // Local requester ports
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [1:0]                 rsp_resp,
    // AXI4-Lite master: write address
    output logic [ADDR_W-1:0]          m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    // AXI4-Lite master: write data
    output logic [DATA_W-1:0]          m_axi_wdata,
    output logic [DATA_W/8-1:0]        m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    // AXI4-Lite master: write response
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    // AXI4-Lite master: read address
    output logic [ADDR_W-1:0]          m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    // AXI4-Lite master: read data
    input  logic [DATA_W-1:0]          m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_strb_w = DATA_W / 8;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wr      = 3'd1;
    localparam logic [2:0] c_st_wr_resp = 3'd2;
    localparam logic [2:0] c_st_rd_addr = 3'd3;
    localparam logic [2:0] c_st_rd_data = 3'd4;
    localparam logic [2:0] c_st_rsp     = 3'd5;

    logic [2:0]          r_state;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  r_gidx;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_strb_w-1:0] r_wstrb;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_arvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_resp;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [c_idx_w-1:0]  w_gidx;
    logic [c_idx_w-1:0]  w_cand;
    logic                w_accept;
    logic                w_aw_done;
    logic                w_w_done;

    // Pick the first eligible requester after the last winner
    always_comb begin
        w_elig  = req_valid;
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
`ifdef ARB_FIXED_PRIO0_EN
        // Requester 0 pre-empts the rotation; the others rotate without it
        if (req_valid[0]) begin
            w_found = 1'b1;
        end
        w_elig[0] = 1'b0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_idx_w'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    // A grant is only taken from IDLE and never while reset is applied
    assign w_accept = (r_state == c_st_idle) && w_found && !reset;

    // An AXI channel is finished when its valid is already low or handshakes now
    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid  || m_axi_wready;

    // One-hot grant strobe and one-hot response pulse for the owning requester
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (w_gidx == c_idx_w'(i));
            rsp_valid[i] = (r_state == c_st_rsp) && (r_gidx == c_idx_w'(i));
        end
    end

    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == c_st_wr_resp);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = (r_state == c_st_rd_data);

    // Transaction sequencer: accept, drive AXI channels, capture response
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_rr_ptr  <= c_idx_w'(NUM_REQ - 1);
            r_gidx    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_gidx  <= w_gidx;
`ifdef ARB_FIXED_PRIO0_EN
                        if (w_gidx != '0) begin
                            r_rr_ptr <= w_gidx;
                        end
`else
                        r_rr_ptr <= w_gidx;
`endif
                        r_addr  <= req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[int'(w_gidx)*DATA_W +: DATA_W];
                        r_wstrb <= req_wstrb[int'(w_gidx)*c_strb_w +: c_strb_w];
                        if (req_write[w_gidx]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_st_wr;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_st_rd_addr;
                        end
                    end
                end
                c_st_wr: begin
                    if (r_awvalid && m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state <= c_st_wr_resp;
                    end
                end
                c_st_wr_resp: begin
                    if (m_axi_bvalid) begin
                        r_resp  <= m_axi_bresp;
                        r_rdata <= '0;
                        r_state <= c_st_rsp;
                    end
                end
                c_st_rd_addr: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= c_st_rd_data;
                    end
                end
                c_st_rd_data: begin
                    if (m_axi_rvalid) begin
                        r_rdata <= m_axi_rdata;
                        r_resp  <= m_axi_rresp;
                        r_state <= c_st_rsp;
                    end
                end
                c_st_rsp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
